// File: rtl/aut_pkg.sv
// Shared definitions for the sequential authentication block: FSM state
// encoding, default parameter values and the reset-time code table.
package aut_pkg;

   // Default parameter values of circuito_autenticacao_seq
   localparam int DEF_CODE_W       = 6;
   localparam int DEF_N_LEVELS     = 3;
   localparam int DEF_MAX_TRIES    = 3;
   localparam int DEF_LOCK_CYCLES  = 16;
   localparam int DEF_GRANT_CYCLES = 4;

   // Default stored codes, one per authorisation level
   localparam logic [5:0] DEF_CODE_L0 = 6'b011100;
   localparam logic [5:0] DEF_CODE_L1 = 6'b101100;
   localparam logic [5:0] DEF_CODE_L2 = 6'b110001;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_GRANT  = 3'd2,
      ST_FAIL   = 3'd3,
      ST_LOCKED = 3'd4
   } aut_state_e;

   // Default code for level idx; levels beyond the table get a
   // deterministic filler so wider configurations still elaborate.
   function automatic logic [31:0] default_code(input int idx);
      logic [31:0] code_v;
      case (idx)
         0:       code_v = {26'd0, DEF_CODE_L0};
         1:       code_v = {26'd0, DEF_CODE_L1};
         2:       code_v = {26'd0, DEF_CODE_L2};
         default: code_v = 32'hFFFF_FFFF - 32'(idx);
      endcase
      return code_v;
   endfunction

endpackage

// File: rtl/aut_code_match.sv
// Combinational comparator of one candidate code against every stored code,
// with a priority encoder so the lowest matching level wins.
module aut_code_match
   import aut_pkg::*;
#(
   parameter int CODE_W   = DEF_CODE_W,
   parameter int N_LEVELS = DEF_N_LEVELS,
   parameter int IDX_W    = 2
) (
   input  logic [CODE_W-1:0] code_i,
   input  logic [CODE_W-1:0] codes_i [N_LEVELS],
   output logic              hit_o,
   output logic [IDX_W-1:0]  idx_o
);

   // Scan from the highest level down so the lowest matching index is kept last
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = N_LEVELS - 1; i >= 0; i--) begin
         hit_o = (codes_i[i] == code_i) ? 1'b1 : hit_o;
         idx_o = (codes_i[i] == code_i) ? IDX_W'(i) : idx_o;
      end
   end

endmodule

// File: rtl/circuito_autenticacao_seq.sv
// Sequential access-code authenticator: accept a code in IDLE, check it
// against the stored table, then grant a level, pulse fail, or lock out
// after too many consecutive failures. Defining AUT_PROG_EN adds a port for
// rewriting stored codes; otherwise the package defaults are constant.
module circuito_autenticacao_seq
   import aut_pkg::*;
#(
   parameter int CODE_W       = DEF_CODE_W,
   parameter int N_LEVELS     = DEF_N_LEVELS,
   parameter int MAX_TRIES    = DEF_MAX_TRIES,
   parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
   parameter int GRANT_CYCLES = DEF_GRANT_CYCLES,
   localparam int IDX_W       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
   localparam int TR_W        = $clog2(MAX_TRIES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CODE_W-1:0]   code_in,
   input  logic                code_valid,
   output logic                ready,
   output logic [N_LEVELS-1:0] aut,
   output logic                fail,
   output logic                locked,
   output logic [TR_W-1:0]     tries
`ifdef AUT_PROG_EN
   ,
   input  logic                prog_we,
   input  logic [IDX_W-1:0]    prog_idx,
   input  logic [CODE_W-1:0]   prog_code
`endif
);

   localparam int CNT_MAX = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   aut_state_e            state_q, state_d;
   logic [CODE_W-1:0]     code_q, code_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TR_W-1:0]       tries_q, tries_d;
   logic                  ready_q, ready_d;
   logic [N_LEVELS-1:0]   aut_q, aut_d;
   logic                  fail_q, fail_d;
   logic                  locked_q, locked_d;

   logic [CODE_W-1:0]     codes_s [N_LEVELS];
   logic                  hit_s;
   logic [IDX_W-1:0]      hit_idx_s;
   logic                  accept_s;

   assign accept_s = code_valid && ready_q;

`ifdef AUT_PROG_EN
   // A write is staged for one cycle before reaching storage, so a code
   // accepted in the same cycle is checked against the pre-write table.
   logic [CODE_W-1:0]     codes_q [N_LEVELS];
   logic [CODE_W-1:0]     codes_d [N_LEVELS];
   logic                  pend_we_q, pend_we_d;
   logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
   logic [CODE_W-1:0]     pend_code_q, pend_code_d;

   // Stage writes issued in IDLE and apply the staged write to storage
   always_comb begin
      codes_d     = codes_q;
      pend_we_d   = prog_we && (state_q == ST_IDLE) && (32'(prog_idx) < N_LEVELS);
      pend_idx_d  = prog_idx;
      pend_code_d = prog_code;
      if (pend_we_q) begin
         codes_d[pend_idx_q] = pend_code_q;
      end else begin
         codes_d = codes_q;
      end
   end

   // Code storage and write staging registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_LEVELS; i++) codes_q[i] <= CODE_W'(default_code(i));
         pend_we_q   <= 1'b0;
         pend_idx_q  <= '0;
         pend_code_q <= '0;
      end else begin
         codes_q     <= codes_d;
         pend_we_q   <= pend_we_d;
         pend_idx_q  <= pend_idx_d;
         pend_code_q <= pend_code_d;
      end
   end

   assign codes_s = codes_q;
`else
   // Fixed code table taken from the package defaults
   always_comb begin
      for (int i = 0; i < N_LEVELS; i++) codes_s[i] = CODE_W'(default_code(i));
   end
`endif

   aut_code_match #(
      .CODE_W   (CODE_W),
      .N_LEVELS (N_LEVELS),
      .IDX_W    (IDX_W)
   ) u_match (
      .code_i  (code_q),
      .codes_i (codes_s),
      .hit_o   (hit_s),
      .idx_o   (hit_idx_s)
   );

   // State, datapath and registered output flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         tries_q  <= '0;
         ready_q  <= 1'b1;
         aut_q    <= '0;
         fail_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         tries_q  <= tries_d;
         ready_q  <= ready_d;
         aut_q    <= aut_d;
         fail_q   <= fail_d;
         locked_q <= locked_d;
      end
   end

   // Next-state, dwell counter and failure counter logic
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tries_d = tries_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               code_d  = code_in;
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            cnt_d = '0;
            if (hit_s) begin
               state_d = ST_GRANT;
               idx_d   = hit_idx_s;
               tries_d = '0;
            end else begin
               state_d = ST_FAIL;
               tries_d = (tries_q == TR_W'(MAX_TRIES)) ? tries_q : tries_q + TR_W'(1);
            end
         end
         ST_GRANT: begin
            if (cnt_q == CNT_W'(GRANT_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_FAIL: begin
            cnt_d = '0;
            if (tries_q == TR_W'(MAX_TRIES)) begin
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               tries_d = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so they register alongside it
   always_comb begin
      ready_d  = 1'b0;
      aut_d    = '0;
      fail_d   = 1'b0;
      locked_d = 1'b0;
      case (state_d)
         ST_IDLE:   ready_d  = 1'b1;
         ST_GRANT:  aut_d    = N_LEVELS'(1'b1) << idx_d;
         ST_FAIL:   fail_d   = 1'b1;
         ST_LOCKED: locked_d = 1'b1;
         default:   ready_d  = 1'b0;
      endcase
   end

   assign ready  = ready_q;
   assign aut    = aut_q;
   assign fail   = fail_q;
   assign locked = locked_q;
   assign tries  = tries_q;

endmodule

// File: tb/tb_circuito_autenticacao_seq.sv
// Directed bench for circuito_autenticacao_seq with default parameters.
// Build with AUT_PROG_EN defined to also exercise the code-write port.
module tb_circuito_autenticacao_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] code_in;
   logic       code_valid;
   logic       ready;
   logic [2:0] aut;
   logic       fail;
   logic       locked;
   logic [1:0] tries;
`ifdef AUT_PROG_EN
   logic       prog_we;
   logic [1:0] prog_idx;
   logic [5:0] prog_code;
`endif

   int total = 0;
   int bad   = 0;

   circuito_autenticacao_seq dut (
      .clk        (clk),
      .rst        (rst),
      .code_in    (code_in),
      .code_valid (code_valid),
      .ready      (ready),
      .aut        (aut),
      .fail       (fail),
      .locked     (locked),
      .tries      (tries)
`ifdef AUT_PROG_EN
      ,
      .prog_we    (prog_we),
      .prog_idx   (prog_idx),
      .prog_code  (prog_code)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a code for one accept cycle; returns in the CHECK cycle
   task automatic send(input logic [5:0] c);
      code_in    = c;
      code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      code_in    = 6'd0;
      code_valid = 1'b0;
`ifdef AUT_PROG_EN
      prog_we    = 1'b0;
      prog_idx   = 2'd0;
      prog_code  = 6'd0;
`endif
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_ready",  32'(ready),  32'd1);
      chk("rst_aut",    32'(aut),    32'd0);
      chk("rst_fail",   32'(fail),   32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_tries",  32'(tries),  32'd0);

      // L1 code: grant 3'b010 on cycles 2..5; L2 attempts during GRANT ignored
      send(6'b101100);
      chk("l1_c1_ready", 32'(ready), 32'd0);
      chk("l1_c1_aut",   32'(aut),   32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("l1_aut",   32'(aut),   32'b010);
         chk("l1_ready", 32'(ready), 32'd0);
         chk("l1_tries", 32'(tries), 32'd0);
         code_in    = 6'b110001;
         code_valid = 1'b1;
         tick();
      end
      code_valid = 1'b0;
      chk("l1_end_aut",   32'(aut),   32'd0);
      chk("l1_end_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("grant_ign_aut",   32'(aut),   32'd0);
         chk("grant_ign_ready", 32'(ready), 32'd1);
      end

      // Three wrong codes: fail pulses with tries 1,2,3, then lockout
      for (int k = 1; k <= 3; k++) begin
         send(6'b000000);
         chk("wr_check_fail", 32'(fail), 32'd0);
         tick();
         chk("wr_fail",  32'(fail),  32'd1);
         chk("wr_tries", 32'(tries), 32'(k));
         chk("wr_aut",   32'(aut),   32'd0);
         tick();
         chk("wr_after_fail", 32'(fail), 32'd0);
         if (k < 3) chk("wr_ready", 32'(ready), 32'd1);
         else       chk("wr_lock_start", 32'(locked), 32'd1);
      end
      // Locked for 16 cycles; the correct L0 code presented meanwhile is ignored
      for (int i = 0; i < 16; i++) begin
         chk("lk_locked", 32'(locked), 32'd1);
         chk("lk_ready",  32'(ready),  32'd0);
         chk("lk_tries",  32'(tries),  32'd3);
         code_in    = 6'b011100;
         code_valid = 1'b1;
         tick();
      end
      code_valid = 1'b0;
      chk("lk_end_locked", 32'(locked), 32'd0);
      chk("lk_end_tries",  32'(tries),  32'd0);
      chk("lk_end_ready",  32'(ready),  32'd1);
      tick();
      tick();
      chk("lk_ign_aut",   32'(aut),   32'd0);
      chk("lk_ign_ready", 32'(ready), 32'd1);

      // Two failures, then L0 grants 3'b001 and clears tries
      for (int k = 1; k <= 2; k++) begin
         send(6'b000000);
         tick();
         chk("f2_tries", 32'(tries), 32'(k));
         tick();
      end
      send(6'b011100);
      tick();
      chk("l0_aut",   32'(aut),   32'b001);
      chk("l0_tries", 32'(tries), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("l0_end_ready", 32'(ready), 32'd1);
      chk("l0_end_aut",   32'(aut),   32'd0);

      // Lock again, then reset on the 2nd LOCKED cycle
      for (int k = 1; k <= 3; k++) begin
         send(6'b111000);
         tick();
         tick();
      end
      chk("lk2_locked", 32'(locked), 32'd1);
      tick();
      chk("lk2_c2_locked", 32'(locked), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("lkrst_locked", 32'(locked), 32'd0);
      chk("lkrst_tries",  32'(tries),  32'd0);
      chk("lkrst_ready",  32'(ready),  32'd1);

      // Reset mid-GRANT leaves no residual grant
      send(6'b110001);
      tick();
      chk("l2_aut", 32'(aut), 32'b100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("grst_aut",   32'(aut),   32'd0);
      chk("grst_ready", 32'(ready), 32'd1);

`ifdef AUT_PROG_EN
      // Write idx 2 with the same code in the accept cycle: checked against old value
      prog_we   = 1'b1;
      prog_idx  = 2'd2;
      prog_code = 6'b111111;
      send(6'b111111);
      prog_we = 1'b0;
      tick();
      chk("pg_fail", 32'(fail), 32'd1);
      chk("pg_aut",  32'(aut),  32'd0);
      tick();
      send(6'b111111);
      tick();
      chk("pg_aut2", 32'(aut), 32'b100);
      for (int i = 0; i < 4; i++) tick();
      // Out-of-range index is ignored: the L0 default still grants
      prog_we   = 1'b1;
      prog_idx  = 2'd3;
      prog_code = 6'b011100;
      tick();
      prog_we = 1'b0;
      send(6'b011100);
      tick();
      chk("pg_oor_aut", 32'(aut), 32'b001);
      for (int i = 0; i < 4; i++) tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
